demux_dist: RTL and testbench
=============================

Name: demux_dist

Overview:
- Registered 1-to-4 distributor: the inverse of a 3-bit-select 5-input mux.
- Accepts one data word plus a 3-bit select per handshake and routes the word to one of four output channels.
- Each channel has its own one-entry holding slot with valid/ready flow control.
- Select 0 is a legal "discard" code; selects 5..7 are illegal and are discarded and counted.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 3, data width of the input and of each output channel.
- CNT_W, 8, width of the saturating drop and error counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  3  destination: 0 = discard, 1..4 = channel o1..o4, 5..7 = illegal.
- in_data  input  WIDTH  word to distribute.
- in_valid  input  1  producer has a word and a select.
- in_ready  output  1  block accepts the word this cycle.
- o1_data, o2_data, o3_data, o4_data  output  WIDTH each  channel data.
- o1_valid, o2_valid, o3_valid, o4_valid  output  1 each  channel slot full.
- o1_ready, o2_ready, o3_ready, o4_ready  input  1 each  consumer takes the word.
- drop_count  output  CNT_W  number of accepted words with sel == 0.
- err_count  output  CNT_W  number of accepted words with sel in 5..7.

Behaviour:
- Reset (synchronous, active-high):
  - All oN_valid = 0, all oN_data = 0, drop_count = 0, err_count = 0.
  - Reset asserted mid-operation discards every pending slot word.
  - During reset, in_ready = 0.
- Accept condition: accept = in_valid && in_ready.
- in_ready is combinational and depends on sel:
  - sel 0 or 5..7: in_ready = 1 (always sinkable).
  - sel k in 1..4: in_ready = !ok_valid || ok_ready, i.e. the slot is empty or is draining this cycle.
  - in_ready may depend on oN_ready. There is no combinational path from in_valid to in_ready.
- Routing, latency 1:
  - A word accepted with sel = k (1..4) appears on ok_data with ok_valid = 1 on the next clock edge.
  - Other channels are unaffected.
- Channel slot update, evaluated per channel in this priority order:
  - Fill this cycle (accept with sel targeting it): valid <= 1, data <= in_data. This covers simultaneous drain and fill, which gives back-to-back throughput of 1 word/cycle.
  - Else drain (valid && ready): valid <= 0. Data holds its last value.
  - Else hold.
- Outputs are stable while valid && !ready: data and valid must not change.
- Counters:
  - Accept with sel == 0 increments drop_count.
  - Accept with sel in 5..7 increments err_count.
  - Both counters saturate at 2^CNT_W - 1 (no wrap).
  - Nothing increments without an accept.
- Combinational case decode: every sel value has an explicit outcome (default branch = error). No latches are inferred; all state is in clocked registers.
- No state machine beyond the per-slot full/empty bit.

Decomposition:
- Package demux_dist_pkg:
  - Select code constants SEL_DROP = 3'd0, SEL_O1..SEL_O4 = 3'd1..3'd4.
  - Function is_err_sel(sel).
- Sub-module demux_slot:
  - One-entry valid/ready holding register.
  - Ports: clk, reset, fill, fill_data, out_data, out_valid, out_ready, can_fill.
  - Instantiated four times. The top level holds the decode, the in_ready mux and the counters.

Test Plan:
- Reset check: assert reset for 2 cycles with in_valid = 1, sel = 1 -> in_ready = 0; all oN_valid = 0, all oN_data = 0, counters = 0 after reset.
- Basic routing: all oN_ready = 1; send (sel = 1, 3'd5), (2, 3'd6), (3, 3'd7), (4, 3'd1) on consecutive cycles -> each word appears on o1..o4 exactly one cycle after its accept; no other channel's valid asserts.
- Backpressure:
  - o2_ready = 0; send sel = 2 data 3'd3, then sel = 2 data 3'd4 -> second word stalls (in_ready = 0), o2_data stays 3'd3.
  - Raise o2_ready -> 3'd3 consumed, 3'd4 accepted the same cycle and shown next cycle.
- Discard and error: send sel = 0 three times, then sel = 6 twice -> in_ready = 1 throughout; drop_count = 3, err_count = 2; no oN_valid asserts.
- Saturation: send 300 words with sel = 7 (CNT_W = 8) -> err_count = 255 and stays 255.
- Reset mid-operation: fill o1 and o3 with consumers stalled, then assert reset one cycle -> o1_valid = o3_valid = 0 and counters = 0 on the next edge; the next word with sel = 3 is delivered normally.

Source files
------------

// File: rtl/demux_dist_pkg.sv
// demux_dist shared definitions: select codes and
// the illegal-select classifier.
package demux_dist_pkg;

    localparam logic [2:0] SEL_DROP = 3'd0;
    localparam logic [2:0] SEL_O1   = 3'd1;
    localparam logic [2:0] SEL_O2   = 3'd2;
    localparam logic [2:0] SEL_O3   = 3'd3;
    localparam logic [2:0] SEL_O4   = 3'd4;

    localparam int NUM_CH = 4;

    function automatic logic is_err_sel(input logic [2:0] sel);
        return sel > SEL_O4;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register for one
// distributor output channel.
module demux_slot #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             can_fill
);

    // Refill is allowed while the current word drains.
    assign can_fill = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fill) begin
            out_valid <= 1'b1;
            out_data  <= fill_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_dist.sv
// Registered 1-to-4 distributor with discard and
// illegal-select sinks plus saturating counters.
module demux_dist
    import demux_dist_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o1_data,
    output logic [WIDTH-1:0] o2_data,
    output logic [WIDTH-1:0] o3_data,
    output logic [WIDTH-1:0] o4_data,
    output logic             o1_valid,
    output logic             o2_valid,
    output logic             o3_valid,
    output logic             o4_valid,
    input  logic             o1_ready,
    input  logic             o2_ready,
    input  logic             o3_ready,
    input  logic             o4_ready,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] fill;
    logic [NUM_CH-1:0] can_fill;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_ready;
    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic              is_drop;
    logic              is_err;
    logic              accept;

    always_comb begin
        hit     = '0;
        is_drop = 1'b0;
        is_err  = 1'b0;
        case (sel)
            SEL_DROP: is_drop = 1'b1;
            SEL_O1:   hit = 4'b0001;
            SEL_O2:   hit = 4'b0010;
            SEL_O3:   hit = 4'b0100;
            SEL_O4:   hit = 4'b1000;
            default:  is_err = is_err_sel(sel);
        endcase
    end

    // Sinks always accept; channels only when their slot frees.
    assign in_ready = !reset
                   && (is_drop || is_err || |(hit & can_fill));
    assign accept   = in_valid && in_ready;
    assign fill     = hit & {NUM_CH{accept}};

    assign ch_ready = {o4_ready, o3_ready, o2_ready, o1_ready};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .fill      (fill[i]),
            .fill_data (in_data),
            .out_data  (ch_data[i]),
            .out_valid (ch_valid[i]),
            .out_ready (ch_ready[i]),
            .can_fill  (can_fill[i])
        );
    end

    assign o1_data  = ch_data[0];
    assign o2_data  = ch_data[1];
    assign o3_data  = ch_data[2];
    assign o4_data  = ch_data[3];
    assign o1_valid = ch_valid[0];
    assign o2_valid = ch_valid[1];
    assign o3_valid = ch_valid[2];
    assign o4_valid = ch_valid[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (accept && is_drop && drop_count != CNT_MAX) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && is_err && err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_dist.sv
// Self-checking bench for demux_dist: directed scenarios
// plus randomized traffic against a slot/counter model.
module tb_demux_dist;

    localparam int W   = 3;
    localparam int CW  = 8;
    localparam int SAT = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    sel;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  o1_data, o2_data, o3_data, o4_data;
    logic          o1_valid, o2_valid, o3_valid, o4_valid;
    logic [3:0]    rdy;
    logic [CW-1:0] drop_count, err_count;

    logic [W-1:0]  od [4];
    logic [3:0]    ov;

    int tests = 0;
    int fails = 0;

    bit           mval [4];
    logic [W-1:0] mdat [4];
    int           mdrop;
    int           merr;

    always #5 clk = ~clk;

    demux_dist #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .o1_data    (o1_data),
        .o2_data    (o2_data),
        .o3_data    (o3_data),
        .o4_data    (o4_data),
        .o1_valid   (o1_valid),
        .o2_valid   (o2_valid),
        .o3_valid   (o3_valid),
        .o4_valid   (o4_valid),
        .o1_ready   (rdy[0]),
        .o2_ready   (rdy[1]),
        .o3_ready   (rdy[2]),
        .o4_ready   (rdy[3]),
        .drop_count (drop_count),
        .err_count  (err_count)
    );

    assign od[0] = o1_data;
    assign od[1] = o2_data;
    assign od[2] = o3_data;
    assign od[3] = o4_data;
    assign ov    = {o4_valid, o3_valid, o2_valid, o1_valid};

    // Readiness as seen by a producer: sinks always open,
    // a channel opens when its slot is empty or draining.
    function automatic bit mready();
        int k;
        if (reset) return 1'b0;
        if (sel == 3'd0 || sel > 3'd4) return 1'b1;
        k = int'(sel) - 1;
        return !mval[k] || rdy[k];
    endfunction

    // One clock edge; the model advances from pre-edge inputs.
    task automatic cyc();
        bit acc;
        int k;
        acc = in_valid && mready();
        k   = int'(sel) - 1;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mval[i] = 1'b0;
                mdat[i] = '0;
            end
            mdrop = 0;
            merr  = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && k == i) begin
                    mval[i] = 1'b1;
                    mdat[i] = in_data;
                end else if (mval[i] && rdy[i]) begin
                    mval[i] = 1'b0;
                end
            end
            if (acc && sel == 3'd0 && mdrop < SAT) mdrop++;
            if (acc && sel > 3'd4 && merr < SAT) merr++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        sel      = 3'd1;
        in_data  = 3'd7;
        rdy      = 4'hF;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_in_ready got=%b exp=0", in_ready);
            end
            cyc();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ov[i] !== 1'b0 || od[i] !== '0) begin
                fails++;
                $display("FAIL reset_ch%0d got v=%b d=%0d exp v=0 d=0",
                         i + 1, ov[i], od[i]);
            end
        end
        tests++;
        if (drop_count !== '0 || err_count !== '0) begin
            fails++;
            $display("FAIL reset_cnt got drop=%0d err=%0d exp 0 0",
                     drop_count, err_count);
        end
    endtask

    task automatic test_routing();
        logic [W-1:0] dv [4];
        dv[0] = 3'd5; dv[1] = 3'd6; dv[2] = 3'd7; dv[3] = 3'd1;
        rdy = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            sel      = 3'(k + 1);
            in_data  = dv[k];
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL route_ready%0d got=%b exp=1", k + 1, in_ready);
            end
            cyc();
            tests++;
            if (ov !== 4'(1 << k) || od[k] !== dv[k]) begin
                fails++;
                $display("FAIL route_o%0d got v=%b d=%0d exp v=%b d=%0d",
                         k + 1, ov, od[k], 4'(1 << k), dv[k]);
            end
        end
        in_valid = 1'b0;
        cyc();
        tests++;
        if (ov !== 4'b0000) begin
            fails++;
            $display("FAIL route_idle got v=%b exp v=0000", ov);
        end
    endtask

    task automatic test_backpressure();
        rdy      = 4'b1101;
        in_valid = 1'b1;
        sel      = 3'd2;
        in_data  = 3'd3;
        cyc();
        in_data = 3'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall got in_ready=%b exp=0", in_ready);
            end
            cyc();
            tests++;
            if (o2_valid !== 1'b1 || o2_data !== 3'd3) begin
                fails++;
                $display("FAIL bp_hold got v=%b d=%0d exp v=1 d=3",
                         o2_valid, o2_data);
            end
        end
        rdy = 4'hF;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got in_ready=%b exp=1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        tests++;
        if (o2_valid !== 1'b1 || o2_data !== 3'd4) begin
            fails++;
            $display("FAIL bp_next got v=%b d=%0d exp v=1 d=4",
                     o2_valid, o2_data);
        end
        cyc();
        tests++;
        if (o2_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain got v=%b exp v=0", o2_valid);
        end
    endtask

    task automatic test_discard();
        do_reset();
        rdy      = 4'hF;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sel     = (c < 3) ? 3'd0 : 3'd6;
            in_data = 3'($urandom);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL disc_ready%0d got=%b exp=1", c, in_ready);
            end
            cyc();
            tests++;
            if (ov !== 4'b0000) begin
                fails++;
                $display("FAIL disc_valid%0d got=%b exp=0000", c, ov);
            end
        end
        in_valid = 1'b0;
        cyc();
        tests++;
        if (drop_count !== 8'd3 || err_count !== 8'd2) begin
            fails++;
            $display("FAIL disc_cnt got drop=%0d err=%0d exp 3 2",
                     drop_count, err_count);
        end
    endtask

    task automatic test_saturation();
        int exp_err;
        do_reset();
        in_valid = 1'b1;
        sel      = 3'd7;
        for (int n = 1; n <= 300; n++) begin
            in_data = 3'($urandom);
            cyc();
            exp_err = (n < SAT) ? n : SAT;
            tests++;
            if (int'(err_count) != exp_err) begin
                fails++;
                $display("FAIL sat_n%0d got err=%0d exp=%0d",
                         n, err_count, exp_err);
            end
        end
        in_valid = 1'b0;
        cyc();
        tests++;
        if (err_count !== 8'd255 || drop_count !== 8'd0) begin
            fails++;
            $display("FAIL sat_hold got err=%0d drop=%0d exp 255 0",
                     err_count, drop_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rdy      = 4'h0;
        in_valid = 1'b1;
        sel      = 3'd0;
        cyc();
        sel     = 3'd1;
        in_data = 3'd2;
        cyc();
        sel     = 3'd3;
        in_data = 3'd6;
        cyc();
        in_valid = 1'b0;
        tests++;
        if (ov !== 4'b0101 || o1_data !== 3'd2 || o3_data !== 3'd6
            || drop_count !== 8'd1) begin
            fails++;
            $display("FAIL mid_fill got v=%b d1=%0d d3=%0d drop=%0d exp 0101 2 6 1",
                     ov, o1_data, o3_data, drop_count);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        tests++;
        if (ov !== 4'b0000 || drop_count !== '0 || err_count !== '0
            || o1_data !== '0 || o3_data !== '0) begin
            fails++;
            $display("FAIL mid_reset got v=%b drop=%0d err=%0d d1=%0d d3=%0d exp zeros",
                     ov, drop_count, err_count, o1_data, o3_data);
        end
        rdy      = 4'hF;
        in_valid = 1'b1;
        sel      = 3'd3;
        in_data  = 3'd5;
        cyc();
        in_valid = 1'b0;
        tests++;
        if (ov !== 4'b0100 || o3_data !== 3'd5) begin
            fails++;
            $display("FAIL mid_after got v=%b d3=%0d exp 0100 5", ov, o3_data);
        end
    endtask

    task automatic test_random();
        bit er;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            sel      = 3'($urandom);
            in_data  = 3'($urandom);
            rdy      = 4'($urandom);
            #1;
            er = mready();
            tests++;
            if (in_ready !== er) begin
                fails++;
                $display("FAIL rnd_ready c=%0d sel=%0d got=%b exp=%b",
                         c, sel, in_ready, er);
            end
            cyc();
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (ov[i] !== mval[i] || (mval[i] && od[i] !== mdat[i])) begin
                    fails++;
                    $display("FAIL rnd_ch%0d c=%0d got v=%b d=%0d exp v=%b d=%0d",
                             i + 1, c, ov[i], od[i], mval[i], mdat[i]);
                end
            end
            tests++;
            if (int'(drop_count) != mdrop || int'(err_count) != merr) begin
                fails++;
                $display("FAIL rnd_cnt c=%0d got drop=%0d err=%0d exp %0d %0d",
                         c, drop_count, err_count, mdrop, merr);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        sel      = 3'd0;
        in_data  = '0;
        rdy      = 4'hF;
        mdrop    = 0;
        merr     = 0;
        for (int i = 0; i < 4; i++) begin
            mval[i] = 1'b0;
            mdat[i] = '0;
        end
        test_reset();
        test_routing();
        test_backpressure();
        test_discard();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
